// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port round-robin front end and power sequencer for a 2048x32 single-port SRAM macro.
// Latency: grant is combinational in the request cycle; read data is strobed on rsp_valid one cycle after grant.
// Backpressure: req_ready is low while the macro sleeps or wakes; responses cannot be stalled.
// Build option: define SRAM_PD_EN to compile in idle power-down (RUN/SLEEP/WAKE sequencing).
module sram_port_arbiter #(
  parameter int AW          = 11,
  parameter int DW          = 32,
  parameter int IDLE_LIMIT  = 16,
  parameter int WAKE_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  input  logic [2*DW-1:0] req_wmask,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            CEB,
  output logic            WEB,
  output logic [AW-1:0]   A,
  output logic [DW-1:0]   D,
  output logic [DW-1:0]   BWEB,
  input  logic [DW-1:0]   Q,
  output logic            PD,
  output logic [1:0]      RTSEL,
  output logic [1:0]      WTSEL
);

  logic          w_run;
  logic          w_any;
  logic          w_gnt;
  logic          w_gnt_port;
  logic          w_gnt_we;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic [DW-1:0] w_gnt_wmask;
  logic          r_ptr;
  logic          r_rsp_vld;
  logic          r_rsp_port;

  assign w_any = |req_valid;
  // With both ports asking the pointer decides; otherwise the lone requester wins.
  assign w_gnt_port  = (&req_valid) ? r_ptr : req_valid[1];
  // RST gates the grant so the macro pins sit at idle values while reset is held.
  assign w_gnt       = w_run & w_any & ~RST;
  assign w_gnt_we    = req_we[w_gnt_port];
  assign w_gnt_addr  = w_gnt_port ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
  assign w_gnt_wdata = w_gnt_port ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign w_gnt_wmask = w_gnt_port ? req_wmask[2*DW-1:DW] : req_wmask[DW-1:0];

  assign req_ready = w_gnt ? (w_gnt_port ? 2'b10 : 2'b01) : 2'b00;
  assign RTSEL     = 2'b01;
  assign WTSEL     = 2'b01;

  // Macro pins follow the granted port in the grant cycle, idle values otherwise
  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    A    = '0;
    D    = '0;
    BWEB = '1;
    if (w_gnt) begin
      CEB = 1'b0;
      WEB = ~w_gnt_we;
      A   = w_gnt_addr;
      D   = w_gnt_wdata;
      if (w_gnt_we) begin
        BWEB = ~w_gnt_wmask;
      end
    end
  end

  // Round-robin pointer and the one-deep read-response tracker
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr      <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_port <= 1'b0;
    end else begin
      r_rsp_vld <= w_gnt & ~w_gnt_we;
      if (w_gnt) begin
        r_ptr      <= ~w_gnt_port;
        r_rsp_port <= w_gnt_port;
      end
    end
  end

  assign rsp_valid = r_rsp_vld ? (r_rsp_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = r_rsp_vld ? Q : '0;

`ifdef SRAM_PD_EN
  localparam int LP_CMAX = (IDLE_LIMIT > WAKE_CYCLES) ? IDLE_LIMIT : WAKE_CYCLES;
  localparam int CW      = $clog2(LP_CMAX + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // State register and the counter shared by the idle and wake phases
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: idle run-down into SLEEP, request-triggered WAKE, timed return to RUN
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_any) begin
          w_cnt_nxt = '0;
        end else if (!r_rsp_vld) begin
          if (r_cnt == CW'(IDLE_LIMIT - 1)) begin
            w_state_nxt = ST_SLEEP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_SLEEP: begin
        if (w_any) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAKE: begin
        if (r_cnt == CW'(WAKE_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    w_run = (r_state == ST_RUN);
    PD    = (r_state == ST_SLEEP);
  end
`else
  assign w_run = 1'b1;
  assign PD    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed stimulus with a behavioural SRAM, a spec-level reference model
// checked every cycle, and literal expectations on the key scenarios.
// Builds with or without SRAM_PD_EN; power-down expectations follow the build.
module tb_sram_port_arbiter;
  localparam int AW          = 11;
  localparam int DW          = 32;
  localparam int IDLE_LIMIT  = 16;
  localparam int WAKE_CYCLES = 4;
`ifdef SRAM_PD_EN
  localparam bit PD_BUILD = 1'b1;
`else
  localparam bit PD_BUILD = 1'b0;
`endif

  logic            CLK;
  logic            RST;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*DW-1:0] req_wmask;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            CEB;
  logic            WEB;
  logic [AW-1:0]   A;
  logic [DW-1:0]   D;
  logic [DW-1:0]   BWEB;
  logic [DW-1:0]   Q;
  logic            PD;
  logic [1:0]      RTSEL;
  logic [1:0]      WTSEL;

  int n_checks = 0;
  int n_errors = 0;

  sram_port_arbiter #(
    .AW(AW), .DW(DW), .IDLE_LIMIT(IDLE_LIMIT), .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB), .Q(Q),
    .PD(PD), .RTSEL(RTSEL), .WTSEL(WTSEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural macro: synchronous read into an output latch, bit-masked write
  logic [DW-1:0] sram [0:2047];
  logic [DW-1:0] q_r = '0;
  assign Q = q_r;
  always @(posedge CLK) begin
    if (!CEB && !PD) begin
      if (!WEB) sram[A] <= (sram[A] & BWEB) | (D & ~BWEB);
      else      q_r <= sram[A];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, arbitration preference, pending read, power mode
  localparam int M_RUN = 0, M_SLEEP = 1, M_WAKE = 2;
  logic [DW-1:0] ref_mem [0:2047];
  int            m_mode = M_RUN;
  int            m_idle = 0;
  int            m_wake = 0;
  bit            m_pref = 1'b0;
  bit            m_pend = 1'b0;
  bit            m_pport = 1'b0;
  logic [DW-1:0] m_pdata = '0;

  bit            g, gp, g_we;
  logic [AW-1:0] g_a;
  logic [DW-1:0] g_d, g_m;
  logic [1:0]    e_rdy, e_rv;
  logic [DW-1:0] e_rd, e_d, e_bweb;
  logic [AW-1:0] e_a;
  logic          e_ceb, e_web, e_pd;

  always @(negedge CLK) begin
    if (RST) begin
      e_rdy = 2'b00; e_rv = 2'b00; e_rd = '0; e_ceb = 1'b1; e_web = 1'b1;
      e_a = '0; e_d = '0; e_bweb = '1; e_pd = 1'b0;
      m_mode = M_RUN; m_pref = 1'b0; m_pend = 1'b0; m_idle = 0; m_wake = 0;
      g = 1'b0; gp = 1'b0; g_we = 1'b0; g_a = '0; g_d = '0; g_m = '0;
    end else begin
      g    = (m_mode == M_RUN) && (req_valid != 2'b00);
      gp   = (req_valid == 2'b11) ? m_pref : req_valid[1];
      g_we = req_we[gp];
      g_a  = gp ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
      g_d  = gp ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
      g_m  = gp ? req_wmask[2*DW-1:DW] : req_wmask[DW-1:0];
      e_rdy  = g ? (gp ? 2'b10 : 2'b01) : 2'b00;
      e_rv   = m_pend ? (m_pport ? 2'b10 : 2'b01) : 2'b00;
      e_rd   = m_pend ? m_pdata : '0;
      e_ceb  = !g;
      e_web  = g ? !g_we : 1'b1;
      e_a    = g ? g_a : '0;
      e_d    = g ? g_d : '0;
      e_bweb = (g && g_we) ? ~g_m : '1;
      e_pd   = (m_mode == M_SLEEP);
    end
    chk("req_ready", req_ready, e_rdy);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_rdata", rsp_rdata, e_rd);
    chk("CEB", CEB, e_ceb);
    chk("WEB", WEB, e_web);
    chk("A", A, e_a);
    chk("D", D, e_d);
    chk("BWEB", BWEB, e_bweb);
    chk("PD", PD, e_pd);
    chk("RTSEL", RTSEL, 2'b01);
    chk("WTSEL", WTSEL, 2'b01);
    if (!RST) begin
      if (PD_BUILD) begin
        case (m_mode)
          M_RUN: begin
            if (req_valid != 2'b00) m_idle = 0;
            else if (!m_pend) begin
              m_idle++;
              if (m_idle == IDLE_LIMIT) begin m_mode = M_SLEEP; m_idle = 0; end
            end
          end
          M_SLEEP: if (req_valid != 2'b00) begin m_mode = M_WAKE; m_wake = 0; end
          default: begin
            m_wake++;
            if (m_wake == WAKE_CYCLES) m_mode = M_RUN;
          end
        endcase
      end
      if (g && !g_we) begin m_pdata = ref_mem[g_a]; m_pport = gp; end
      if (g && g_we) ref_mem[g_a] = (ref_mem[g_a] & ~g_m) | (g_d & g_m);
      if (g) m_pref = !gp;
      m_pend = g && !g_we;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; req_wmask = '0;
  endtask

  task automatic set_req(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    if (p) begin
      req_addr[2*AW-1:AW] = a; req_wdata[2*DW-1:DW] = d; req_wmask[2*DW-1:DW] = m;
    end else begin
      req_addr[AW-1:0] = a; req_wdata[DW-1:0] = d; req_wmask[DW-1:0] = m;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  int wait_cnt;

  initial begin
    RST = 1'b1;
    clr();
    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 2'($urandom_range(1, 3));
      req_we    = 2'($urandom_range(0, 3));
      req_addr  = 22'($urandom);
      req_wdata = {$urandom, $urandom};
      req_wmask = {$urandom, $urandom};
      #2;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_ceb", CEB, 1'b1);
      chk("rst_bweb", BWEB, 32'hFFFFFFFF);
      chk("rst_pd", PD, 1'b0);
    end
    tick();
    clr();
    RST = 1'b0;
    #2;
    chk("post_rst_ceb", CEB, 1'b1);

    // Full write then readback on port 0
    tick();
    set_req(1'b0, 1'b1, 11'h005, 32'hDEADBEEF, 32'hFFFFFFFF);
    #2;
    chk("wr_ceb", CEB, 1'b0);
    chk("wr_web", WEB, 1'b0);
    chk("wr_bweb", BWEB, 32'h0);
    chk("wr_ready", req_ready, 2'b01);
    tick();
    clr();
    set_req(1'b0, 1'b0, 11'h005, 32'h0, 32'h0);
    #2;
    chk("rd_ready", req_ready, 2'b01);
    tick();
    clr();
    #2;
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);

    // Preload for the round-robin reads; leaves the pointer at port 0
    tick();
    set_req(1'b0, 1'b1, 11'h010, 32'h01010101, 32'hFFFFFFFF);
    tick();
    clr();
    set_req(1'b1, 1'b1, 11'h020, 32'h02020202, 32'hFFFFFFFF);
    tick();
    clr();
    set_req(1'b0, 1'b0, 11'h010, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 11'h020, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("rr_rsp_valid", rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_rdata", rsp_rdata, (k % 2 == 1) ? 32'h01010101 : 32'h02020202);
      end
      tick();
    end
    clr();
    #2;
    chk("rr_last_valid", rsp_valid, 2'b10);
    chk("rr_last_rdata", rsp_rdata, 32'h02020202);

    // Partial write onto a known word
    tick();
    set_req(1'b0, 1'b1, 11'h030, 32'hAAAAAAAA, 32'hFFFFFFFF);
    tick();
    clr();
    set_req(1'b0, 1'b1, 11'h030, 32'h12345678, 32'h0000FFFF);
    #2;
    chk("pw_bweb", BWEB, 32'hFFFF0000);
    tick();
    clr();
    set_req(1'b0, 1'b0, 11'h030, 32'h0, 32'h0);
    tick();
    clr();
    #2;
    chk("pw_rsp_valid", rsp_valid, 2'b01);
    chk("pw_rdata", rsp_rdata, 32'hAAAA5678);

    // Idle into power-down, then wake on a port-1 request
    repeat (IDLE_LIMIT) tick();
    #2;
    chk("idle_pd_low", PD, 1'b0);
    tick();
    #2;
    chk("idle_pd_high", PD, PD_BUILD);
    tick();
    set_req(1'b1, 1'b0, 11'h005, 32'h0, 32'h0);
    #2;
    wait_cnt = 0;
    while (!req_ready[1] && wait_cnt < 40) begin
      tick();
      #2;
      wait_cnt++;
    end
    chk("wake_latency", wait_cnt, PD_BUILD ? WAKE_CYCLES + 1 : 0);
    tick();
    clr();
    #2;
    chk("wake_rsp_valid", rsp_valid, 2'b10);
    chk("wake_rdata", rsp_rdata, 32'hDEADBEEF);

    // Reset during a read grant: response dropped, pointer back to 0
    tick();
    set_req(1'b0, 1'b1, 11'h040, 32'h00000005, 32'hFFFFFFFF);
    #2;
    chk("pre_rst_wr_ready", req_ready, 2'b01);
    tick();
    clr();
    set_req(1'b0, 1'b0, 11'h040, 32'h0, 32'h0);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 2'b00);
    tick();
    RST = 1'b0;
    clr();
    #2;
    chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 11'h010, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 11'h020, 32'h0, 32'h0);
    #2;
    chk("ptr_after_rst", req_ready, 2'b01);
    tick();
    clr();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port round-robin arbiter and power sequencer in front of the single-port 2048x32 SRAM macro (TS1N40LPB2048X32M4FWBA). It accepts read/write requests from two requesters over valid/ready handshakes and drives the macro's normal-mode pins (CEB, WEB, A, D, BWEB, PD, RTSEL, WTSEL). It returns read data one cycle after grant and optionally puts the macro into power-down when idle. The parent ties off the BIST-mode pins: BIST=0, CEBM=1, WEBM=1, AWT=0, AM=0, DM=0, BWEBM=all ones.

## Interface
- AW, 11, address width (2048 words)
- DW, 32, data width
- IDLE_LIMIT, 16, consecutive idle cycles before power-down (>=1)
- WAKE_CYCLES, 4, cycles PD is held low before the first access after wake (>=1)

Clock and reset: one clock; reset is asynchronous and active-high. Ports:
- CLK  in  1  clock, same clock as the SRAM macro
- RST  in  1  asynchronous active-high reset
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port grant; transfer occurs when valid&ready at rising CLK
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2*AW  port i at [i*AW +: AW]
- req_wdata  in  2*DW  write data
- req_wmask  in  2*DW  active-high bit write mask (1 = write bit)
- rsp_valid  out  2  one-cycle read-data strobe per port
- rsp_rdata  out  DW  read data, shared by both ports, qualified by rsp_valid
- CEB  out  1  SRAM chip enable, active low
- WEB  out  1  SRAM write enable, active low (1 = read)
- A  out  AW  SRAM address
- D  out  DW  SRAM write data
- BWEB  out  DW  SRAM bit write enable, active low (= ~wmask)
- Q  in  DW  SRAM read data
- PD  out  1  SRAM power-down
- RTSEL  out  2  constant 2'b01
- WTSEL  out  2  constant 2'b01

## Operation
- FSM states: RUN, SLEEP, WAKE. Reset state is RUN.
- RUN:
  - If any req_valid is set, grant exactly one port per cycle. req_ready is combinational from req_valid, the RR pointer and the state.
  - Round-robin: the pointer names the preferred port and resets to 0. If both ports are valid, grant the pointer port. If only one is valid, grant it. After any grant, the pointer becomes the non-granted port.
  - In the grant cycle, the SRAM pins are combinational from the granted port: CEB=0, WEB=~we, A=addr, D=wdata, BWEB=~wmask (reads drive BWEB=all ones).
  - With no grant: CEB=1, WEB=1, A=0, D=0, BWEB=all ones.
- Read response:
  - A granted read sets a registered flag rsp_port.
  - Next cycle, rsp_valid[rsp_port]=1 and rsp_rdata=Q. Otherwise rsp_rdata=0.
  - There is no response backpressure: requesters must accept.
- Writes produce no response.
- Idle counter:
  - Counts RUN cycles with req_valid==0 and no pending response.
  - Clears on any req_valid.
  - On reaching IDLE_LIMIT the FSM enters SLEEP (PD=1, CEB=1) and the counter clears.
- SLEEP: any req_valid moves to WAKE; PD=0 in the same cycle the FSM registers WAKE.
- WAKE: the counter counts WAKE_CYCLES cycles, then the FSM enters RUN. req_ready=0 throughout SLEEP and WAKE; requests stay pending (valid must hold).
- Reset mid-operation: all state clears immediately (async) and any in-flight read response is dropped.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, CEB=1, WEB=1, A=0, D=0, BWEB=all ones, PD=0, RTSEL=01, WTSEL=01, FSM=RUN, pointer=0, counters=0.
- Read latency: grant edge N, rsp_valid high during cycle N+1, exactly 1 cycle wide.
- Throughput: one access per cycle. Back-to-back reads from alternating ports give rsp_valid on consecutive cycles.
- Simultaneous grant and response in one cycle is legal: the response is for the previous grant.
- Wake latency: valid rising in SLEEP to first req_ready = WAKE_CYCLES+1 cycles.
- Idle entry: PD rises IDLE_LIMIT+1 cycles after the last accepted request's response cycle.

## Configuration
- SRAM_PD_EN defined: the SLEEP/WAKE FSM, idle counter and wake counter are compiled in, as described above.
- SRAM_PD_EN undefined: PD is tied to 0, the FSM is permanently RUN, and IDLE_LIMIT and WAKE_CYCLES are ignored. Wake latency is 0.

## Test plan
- Reset with RST=1 while inputs toggle -> all outputs hold their reset values. Release RST -> RUN, CEB=1.
- Port0 write addr 0x005, data 0xDEADBEEF, mask 0xFFFFFFFF, then port0 read 0x005 -> CEB=0/WEB=0/BWEB=0 on the write cycle. The read returns rsp_valid[0] one cycle after grant, with rsp_rdata=0xDEADBEEF.
- Both ports hold valid reads (0x010 and 0x020) for 4 cycles -> grants alternate 0,1,0,1. rsp_valid alternates correspondingly with correct data.
- Partial write with mask 0x0000FFFF, data 0x12345678 onto a word holding 0xAAAAAAAA -> readback 0xAAAA5678.
- SRAM_PD_EN, IDLE_LIMIT=16, WAKE_CYCLES=4: idle 17+ cycles -> PD=1. Then port1 asserts valid -> PD=0 next edge, req_ready[1] after 5 cycles, and the access completes.
- Assert RST during a read's grant cycle -> no rsp_valid follows. The pointer returns to 0.
